// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder.
// Takes one fetch per cycle, reads the instruction store through a fixed-latency
// pipeline and returns address/instruction pairs in order through a small
// response FIFO. A credit count of accepted-but-not-popped requests keeps the
// pipeline plus FIFO from ever holding more than FIFO_DEPTH entries, so the FIFO
// needs no full check. Flush drops everything in flight; the load port writes
// the store at any time with read-before-write ordering against fetches.
module imem_fetch_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic [31:0]                    req_addr_i,
   input  logic                           flush_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [31:0]                    rsp_addr_o,
   output logic [31:0]                    rsp_instr_o,
   output logic                           rsp_err_o,
   input  logic                           load_en_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
   input  logic [31:0]                    load_data_i
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [30:0]   WORD_LIMIT = 31'(DEPTH_WORDS);
   localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CREDIT_ONE = CW'(1);
   localparam logic [PW:0]   PTR_ONE    = (PW + 1)'(1);

   logic [31:0]         mem_q [DEPTH_WORDS];

   logic [LATENCY-1:0]  pvld_q, pvld_d;
   logic [LATENCY-1:0]  perr_q;
   logic [31:0]         paddr_q [LATENCY];
   logic [31:0]         pdata_q [LATENCY];

   logic [31:0]         faddr_q  [FIFO_DEPTH];
   logic [31:0]         finstr_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] ferr_q;
   logic [PW:0]         wr_ptr_q, wr_ptr_d;
   logic [PW:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       credits_q, credits_d;

   logic                accept, pop, push, req_err;
   logic [AW-1:0]       req_idx;
   logic [PW-1:0]       head;

   assign req_idx     = req_addr_i[AW+1:2];
   assign req_err     = (req_addr_i[1:0] != 2'b00) || ({1'b0, req_addr_i[31:2]} >= WORD_LIMIT);
   assign req_ready_o = (credits_q < CREDIT_MAX) && !flush_i;
   assign accept      = req_valid_i && req_ready_o;
   assign rsp_valid_o = (wr_ptr_q != rd_ptr_q);
   assign pop         = rsp_valid_o && rsp_ready_i;
   assign push        = pvld_q[LATENCY-1];
   assign head        = rd_ptr_q[PW-1:0];

   // Head fields are forced to zero whenever the FIFO is empty so reset and
   // flush never expose stale storage.
   assign rsp_addr_o  = rsp_valid_o ? faddr_q[head]  : 32'h0;
   assign rsp_instr_o = rsp_valid_o ? finstr_q[head] : 32'h0;
   assign rsp_err_o   = rsp_valid_o ? ferr_q[head]   : 1'b0;

   // Next-state for pipeline valids, FIFO pointers and credits; flush wins.
   always_comb begin
      pvld_d    = '0;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      credits_d = credits_q;
      pvld_d[0] = accept;
      for (int i = 1; i < int'(LATENCY); i++) begin
         pvld_d[i] = pvld_q[i-1];
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (accept && !pop) credits_d = credits_q + CREDIT_ONE;
      if (!accept && pop) credits_d = credits_q - CREDIT_ONE;
      if (flush_i) begin
         pvld_d    = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         credits_d = '0;
      end
   end

   // Control state register; reset clears valids, pointers and credits at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pvld_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         credits_q <= '0;
      end else begin
         pvld_q    <= pvld_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         credits_q <= credits_d;
      end
   end

   // Datapath: store write, read-before-write fetch, pipeline shift, FIFO write.
   always_ff @(posedge clk_i) begin
      if (load_en_i) mem_q[load_addr_i] <= load_data_i;
      paddr_q[0] <= req_addr_i;
      perr_q[0]  <= req_err;
      pdata_q[0] <= req_err ? 32'h0 : mem_q[req_idx];
      for (int i = 1; i < int'(LATENCY); i++) begin
         paddr_q[i] <= paddr_q[i-1];
         perr_q[i]  <= perr_q[i-1];
         pdata_q[i] <= pdata_q[i-1];
      end
      if (push) begin
         faddr_q[wr_ptr_q[PW-1:0]]  <= paddr_q[LATENCY-1];
         finstr_q[wr_ptr_q[PW-1:0]] <= pdata_q[LATENCY-1];
         ferr_q[wr_ptr_q[PW-1:0]]   <= perr_q[LATENCY-1];
      end
   end

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;

   localparam int LAT   = 2;
   localparam int FDEP  = 4;
   localparam int DW    = 1024;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_addr_i = 32'h0;
   logic        flush_i = 1'b0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_addr_o;
   logic [31:0] rsp_instr_o;
   logic        rsp_err_o;
   logic        load_en_i = 1'b0;
   logic [9:0]  load_addr_i = '0;
   logic [31:0] load_data_i = 32'h0;

   imem_fetch_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT), .FIFO_DEPTH(FDEP)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .flush_i(flush_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_addr_o(rsp_addr_o), .rsp_instr_o(rsp_instr_o), .rsp_err_o(rsp_err_o),
      .load_en_i(load_en_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        err;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl_mem [DW];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          acc_cnt = 0;
   int          pop_cnt = 0;
   int          acc_cyc[$];
   int          pop_cyc[$];
   logic [31:0] last_addr, last_instr;
   logic        last_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         chk("rst_valid", {31'h0, rsp_valid_o}, 32'h0);
         chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
         chk("rst_addr", rsp_addr_o, 32'h0);
         chk("rst_instr", rsp_instr_o, 32'h0);
         chk("rst_err", {31'h0, rsp_err_o}, 32'h0);
         sb.delete();
      end else begin
         chk("valid", {31'h0, rsp_valid_o},
             {31'h0, (sb.size() > 0 && sb[0].due <= cyc)});
         chk("ready", {31'h0, req_ready_o}, {31'h0, (sb.size() < FDEP && !flush_i)});
         if (rsp_valid_o && sb.size() > 0) begin
            chk("rsp_addr", rsp_addr_o, sb[0].addr);
            chk("rsp_instr", rsp_instr_o, sb[0].instr);
            chk("rsp_err", {31'h0, rsp_err_o}, {31'h0, sb[0].err});
         end
         if (flush_i) begin
            sb.delete();
         end else begin
            if (rsp_valid_o && rsp_ready_i && sb.size() > 0) begin
               last_addr  = rsp_addr_o;
               last_instr = rsp_instr_o;
               last_err   = rsp_err_o;
               pop_cyc.push_back(cyc);
               pop_cnt++;
               void'(sb.pop_front());
            end
            if (req_valid_i && req_ready_o) begin
               exp_t e;
               e.addr  = req_addr_i;
               e.err   = (req_addr_i[1:0] != 2'b00) || ((req_addr_i >> 2) >= DW);
               e.instr = e.err ? 32'h0 : mdl_mem[req_addr_i[11:2]];
               e.due   = cyc + 1 + LAT;
               sb.push_back(e);
               acc_cyc.push_back(cyc);
               acc_cnt++;
            end
         end
         if (load_en_i) mdl_mem[load_addr_i] = load_data_i;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic [31:0] a);
      int n;
      n = 0;
      req_valid_i = 1'b1;
      req_addr_i  = a;
      @(negedge clk_i);
      while (!req_ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 200) chk("send_timeout", 32'h0, 32'h1);
      step();
      req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) chk("drain_timeout", 32'h0, 32'h1);
      step();
   endtask

   task automatic load(input int idx, input logic [31:0] d);
      load_en_i   = 1'b1;
      load_addr_i = 10'(idx);
      load_data_i = d;
      step();
      load_en_i   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_acc, base_pop;
      #2 rst_ni = 1'b0;
      repeat (3) step();
      rst_ni = 1'b1;
      step();

      // Preload the store: words 0..3 per test plan, the rest with a marker pattern.
      for (int i = 0; i < 32; i++) begin
         load(i, (i < 4) ? (32'h2008_0001 + 32'(i)) : (32'hA500_0000 + 32'(i)));
      end

      // In-order back-to-back fetch with the consumer always ready.
      rsp_ready_i = 1'b1;
      acc_cyc.delete();
      pop_cyc.delete();
      for (int i = 0; i < 4; i++) send(32'(i * 4));
      drain();
      chk("inorder_count", 32'(pop_cyc.size()), 32'd4);
      if (pop_cyc.size() == 4 && acc_cyc.size() == 4) begin
         chk("first_latency", 32'(pop_cyc[0] - acc_cyc[0]), 32'(1 + LAT));
         chk("no_bubbles", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);
      end
      chk("inorder_last", last_instr, 32'h2008_0004);

      // Backpressure: only FIFO_DEPTH accepted while the consumer stalls.
      rsp_ready_i = 1'b0;
      base_acc = acc_cnt;
      base_pop = pop_cnt;
      fork
         begin
            for (int i = 0; i < 6; i++) send(32'(i * 4));
         end
         begin
            repeat (10) step();
            chk("bp_accepted", 32'(acc_cnt - base_acc), 32'd4);
            chk("bp_req_ready", {31'h0, req_ready_o}, 32'h0);
            chk("bp_head_addr", rsp_addr_o, 32'h0);
            chk("bp_head_instr", rsp_instr_o, 32'h2008_0001);
            rsp_ready_i = 1'b1;
         end
      join
      drain();
      chk("bp_total_acc", 32'(acc_cnt - base_acc), 32'd6);
      chk("bp_total_pop", 32'(pop_cnt - base_pop), 32'd6);
      chk("bp_last_addr", last_addr, 32'h14);

      // Misaligned and out-of-range fetches, then a normal one.
      send(32'h2);
      send(32'h1000);
      send(32'h8);
      drain();
      chk("err_after_addr", last_addr, 32'h8);
      chk("err_after_err", {31'h0, last_err}, 32'h0);
      chk("err_after_instr", last_instr, 32'h2008_0003);

      // Flush with three responses outstanding.
      rsp_ready_i = 1'b0;
      send(32'h0);
      send(32'h4);
      send(32'h8);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      @(negedge clk_i);
      chk("flush_valid", {31'h0, rsp_valid_o}, 32'h0);
      chk("flush_ready", {31'h0, req_ready_o}, 32'h1);
      step();
      base_pop = pop_cnt;
      rsp_ready_i = 1'b1;
      send(32'h40);
      drain();
      repeat (4) step();
      chk("flush_pops", 32'(pop_cnt - base_pop), 32'd1);
      chk("flush_next_addr", last_addr, 32'h40);

      // Load collision: same-cycle fetch sees the old word, next fetch the new one.
      load_en_i   = 1'b1;
      load_addr_i = 10'd5;
      load_data_i = 32'hDEAD_BEEF;
      send(32'h14);
      load_en_i   = 1'b0;
      drain();
      chk("collide_old", last_instr, 32'hA500_0005);
      send(32'h14);
      drain();
      chk("collide_new", last_instr, 32'hDEAD_BEEF);

      // Reset mid-stream with three credits outstanding.
      rsp_ready_i = 1'b0;
      send(32'h0);
      send(32'h4);
      send(32'h8);
      base_pop = pop_cnt;
      rst_ni = 1'b0;
      #1;
      chk("midrst_valid", {31'h0, rsp_valid_o}, 32'h0);
      chk("midrst_ready", {31'h0, req_ready_o}, 32'h1);
      repeat (2) step();
      rst_ni = 1'b1;
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      chk("postrst_ready", {31'h0, req_ready_o}, 32'h1);
      repeat (8) step();
      chk("postrst_no_stale", 32'(pop_cnt - base_pop), 32'd0);
      send(32'hC);
      drain();
      chk("postrst_fetch", last_instr, 32'h2008_0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
